// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: host-side bus sequencer for an 8259-style interrupt controller
//   clk, rst_n                      : clock, asynchronous active-low reset
//   cfg_start/cfg_icw1..4/cfg_ocw1  : init sequence trigger and ICW/OCW values
//   cfg_busy, cfg_done              : init in progress / init completed
//   cmd_*                           : single host register read/write handshake
//   rsp_valid, rsp_rdata            : read data return
//   int_en, pic_int                 : automatic acknowledge enable, controller INT
//   vec_valid, vec_data             : captured interrupt vector
//   pic_* , db_out, db_oe, db_in    : controller bus pins (split data bus)
module pic_host_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int GAP_CYC   = 2,
    parameter int ACK_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [7:0] cfg_icw1,
    input  logic [7:0] cfg_icw2,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_icw4,
    input  logic [7:0] cfg_ocw1,
    output logic       cfg_busy,
    output logic       cfg_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    input  logic       int_en,
    input  logic       pic_int,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       pic_cs_n,
    output logic       pic_a0,
    output logic       pic_wr_n,
    output logic       pic_rd_n,
    output logic       pic_inta_n,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in
);
    typedef enum logic [3:0] {
        IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_HOLD, A_P1, A_GAP, A_P2, A_END
    } state_t;
    localparam int GW = $clog2(ACK_GAP + 2);
    localparam logic [2:0] STEP_END = 3'd5;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_cnt, w_cnt_nxt;
    logic [GW-1:0] r_gap;
    logic [1:0]    r_int_s;
    logic          r_run;
    logic [2:0]    r_step, w_step_nxt;
    logic [7:0]    r_icw1, r_icw2, r_icw3, r_icw4, r_ocw1, w_step_d, w_launch_d;
    logic          w_last, w_idle, w_cfg_go, w_cfg_wr, w_int_go, w_cmd_go, w_launch, w_launch_a0;
    assign w_last   = r_cnt == 8'd0;
    assign w_idle   = r_state == IDLE;
    assign w_cfg_go = w_idle && cfg_start && !cfg_busy;
    assign w_cfg_wr = w_idle && cfg_busy && r_step != STEP_END;
    // cfg_done is only set while not busy, so it also keeps INTA out of the init sequence
    assign w_int_go = w_idle && !w_cfg_go && cfg_done && int_en && r_int_s[1] && r_gap == '0;
    // r_run holds cmd_ready low during reset even though the FSM already sits in IDLE
    assign cmd_ready = w_idle && r_run && !cfg_busy && !w_cfg_go && !w_int_go;
    assign w_cmd_go  = cmd_ready && cmd_valid;
    assign w_launch  = w_cfg_wr || w_cmd_go;
    // ICW3 only in cascade mode (SNGL=0), ICW4 only when IC4=1
    assign w_step_d = r_step == 3'd0 ? r_icw1 : r_step == 3'd1 ? r_icw2 :
                      r_step == 3'd2 ? r_icw3 : r_step == 3'd3 ? r_icw4 : r_ocw1;
    assign w_step_nxt = r_step == 3'd1 ? (!r_icw1[1] ? 3'd2 : r_icw1[0] ? 3'd3 : 3'd4) :
                        r_step == 3'd2 ? (r_icw1[0] ? 3'd3 : 3'd4) : r_step + 3'd1;
    assign w_launch_a0 = w_cfg_wr ? r_step != 3'd0 : cmd_a0;
    assign w_launch_d  = w_cfg_wr ? w_step_d : cmd_wdata;
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last ? r_cnt : r_cnt - 8'd1;
        case (r_state)
            IDLE: begin
                if (w_cfg_wr || (w_cmd_go && cmd_write)) begin
                    w_state_nxt = W_SETUP;
                    w_cnt_nxt   = 8'(SETUP_CYC - 1);
                end else if (w_cmd_go) begin
                    w_state_nxt = R_SETUP;
                    w_cnt_nxt   = 8'(SETUP_CYC - 1);
                end else if (w_int_go) begin
                    w_state_nxt = A_P1;
                    w_cnt_nxt   = 8'(PULSE_CYC - 1);
                end
            end
            W_SETUP: if (w_last) begin w_state_nxt = W_PULSE; w_cnt_nxt = 8'(PULSE_CYC - 1); end
            W_PULSE: if (w_last) begin w_state_nxt = W_HOLD;  w_cnt_nxt = 8'(HOLD_CYC - 1); end
            W_HOLD:  if (w_last) w_state_nxt = IDLE;
            R_SETUP: if (w_last) begin w_state_nxt = R_PULSE; w_cnt_nxt = 8'(PULSE_CYC - 1); end
            R_PULSE: if (w_last) begin w_state_nxt = R_HOLD;  w_cnt_nxt = 8'(HOLD_CYC - 1); end
            R_HOLD:  if (w_last) w_state_nxt = IDLE;
            A_P1:    if (w_last) begin w_state_nxt = A_GAP;   w_cnt_nxt = 8'(GAP_CYC - 1); end
            A_GAP:   if (w_last) begin w_state_nxt = A_P2;    w_cnt_nxt = 8'(PULSE_CYC - 1); end
            A_P2:    if (w_last) w_state_nxt = A_END;
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    // Bus pins are registered from the next state so they never glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_s    <= 2'b00;
            r_run      <= 1'b0;
            r_gap      <= '0;
            pic_cs_n   <= 1'b1;
            pic_wr_n   <= 1'b1;
            pic_rd_n   <= 1'b1;
            pic_inta_n <= 1'b1;
            pic_a0     <= 1'b0;
            db_out     <= 8'd0;
            db_oe      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'd0;
            vec_valid  <= 1'b0;
            vec_data   <= 8'd0;
            cfg_busy   <= 1'b0;
            cfg_done   <= 1'b0;
            r_step     <= 3'd0;
            r_icw1     <= 8'd0;
            r_icw2     <= 8'd0;
            r_icw3     <= 8'd0;
            r_icw4     <= 8'd0;
            r_ocw1     <= 8'd0;
        end else begin
            r_int_s    <= {r_int_s[0], pic_int};
            r_run      <= 1'b1;
            r_gap      <= r_state == A_END ? GW'(ACK_GAP) : r_gap - GW'(r_gap != '0);
            pic_cs_n   <= !(w_state_nxt inside {W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_HOLD});
            pic_wr_n   <= w_state_nxt != W_PULSE;
            pic_rd_n   <= w_state_nxt != R_PULSE;
            pic_inta_n <= !(w_state_nxt inside {A_P1, A_P2});
            db_oe      <= w_state_nxt inside {W_SETUP, W_PULSE, W_HOLD};
            if (w_launch) begin
                pic_a0 <= w_launch_a0;
                db_out <= w_launch_d;
            end
            rsp_valid <= r_state == R_HOLD && w_last;
            if (r_state == R_PULSE && w_last) rsp_rdata <= db_in;
            vec_valid <= r_state == A_P2 && w_last;
            if (r_state == A_P2 && w_last) vec_data <= db_in;
            if (w_cfg_go) begin
                cfg_busy <= 1'b1;
                cfg_done <= 1'b0;
                r_step   <= 3'd0;
                r_icw1   <= cfg_icw1;
                r_icw2   <= cfg_icw2;
                r_icw3   <= cfg_icw3;
                r_icw4   <= cfg_icw4;
                r_ocw1   <= cfg_ocw1;
            end else if (w_cfg_wr) begin
                r_step <= w_step_nxt;
            end else if (w_idle && cfg_busy) begin
                cfg_busy <= 1'b0;
                cfg_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: scoreboard bench for pic_host_sequencer
module tb_pic_host_sequencer;
    localparam int SETUP = 1, PULSE = 2, HOLD = 1, GAP = 2, AGAP = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cfg_start = 0, cfg_busy, cfg_done;
    logic [7:0] cfg_icw1 = 0, cfg_icw2 = 0, cfg_icw3 = 0, cfg_icw4 = 0, cfg_ocw1 = 0;
    logic cmd_valid = 0, cmd_ready, cmd_write = 0, cmd_a0 = 0;
    logic [7:0] cmd_wdata = 0;
    logic rsp_valid, vec_valid, int_en = 0, pic_int = 0;
    logic [7:0] rsp_rdata, vec_data, db_out, db_in;
    logic pic_cs_n, pic_a0, pic_wr_n, pic_rd_n, pic_inta_n, db_oe;
    pic_host_sequencer #(.SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD),
                         .GAP_CYC(GAP), .ACK_GAP(AGAP)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_icw1(cfg_icw1),
        .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3), .cfg_icw4(cfg_icw4), .cfg_ocw1(cfg_ocw1),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .int_en(int_en), .pic_int(pic_int), .vec_valid(vec_valid),
        .vec_data(vec_data), .pic_cs_n(pic_cs_n), .pic_a0(pic_a0), .pic_wr_n(pic_wr_n),
        .pic_rd_n(pic_rd_n), .pic_inta_n(pic_inta_n), .db_out(db_out), .db_oe(db_oe),
        .db_in(db_in));
    always #5 clk = ~clk;
    int n_vec = 0, n_err = 0;
    logic [8:0] wq[$];
    logic [7:0] rq[$], vq[$];
    // controller model: vector only on the second INTA pulse, junk on the first
    logic [7:0] rdval = 8'h00, vecv = 8'h00;
    int pnum = 0;
    always @(negedge pic_inta_n) pnum = (pnum == 1) ? 2 : 1;
    assign db_in = !pic_inta_n ? (pnum == 2 ? vecv : 8'hAA) : !pic_rd_n ? rdval : 8'hFF;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask
    // bus monitor / scoreboard
    int cs_len = 0, wr_len = 0, rd_len = 0, oe_len = 0, lo = 0, hi = 0, ph = 0, seqs = 0;
    int n_wr = 0, vseen = 0, acc_vseen = 0;
    logic prev_cs = 1, prev_inta = 1;
    logic [8:0] cap;
    always @(negedge clk) begin
        if (!rst_n) begin
            cs_len = 0; wr_len = 0; rd_len = 0; oe_len = 0;
            lo = 0; hi = 0; ph = 0; seqs = 0; prev_cs = 1; prev_inta = 1;
        end else begin
            if (!pic_cs_n) begin
                cs_len++;
                if (!pic_wr_n) begin wr_len++; cap = {pic_a0, db_out}; end
                if (!pic_rd_n) rd_len++;
                if (db_oe) oe_len++;
            end else if (!prev_cs) begin
                chk("cs_width", cs_len, SETUP + PULSE + HOLD);
                if (wr_len > 0) begin
                    chk("wr_width", wr_len, PULSE);
                    chk("wr_oe_cycles", oe_len, cs_len);
                    if (wq.size() == 0) fail("wr_unexpected");
                    else chk("wr_a0_data", cap, wq.pop_front());
                    n_wr++;
                end else begin
                    chk("rd_width", rd_len, PULSE);
                    chk("rd_oe_cycles", oe_len, 0);
                end
                cs_len = 0; wr_len = 0; rd_len = 0; oe_len = 0;
            end
            prev_cs = pic_cs_n;
            if (pic_inta_n && !prev_inta) begin
                chk("inta_width", lo, PULSE);
                hi = 0;
            end else if (!pic_inta_n && prev_inta) begin
                if (ph == 1) begin
                    chk("inta_gap", hi, GAP);
                    ph = 0;
                end else begin
                    if (seqs > 0) chk("ack_gap_respected", hi >= AGAP, 1);
                    seqs++;
                    ph = 1;
                end
                lo = 0;
            end
            if (pic_inta_n) hi++; else lo++;
            prev_inta = pic_inta_n;
            if (rsp_valid) begin
                if (rq.size() == 0) fail("rsp_unexpected");
                else chk("rsp_rdata", rsp_rdata, rq.pop_front());
            end
            if (vec_valid) begin
                vseen++;
                if (vq.size() == 0) fail("vec_unexpected");
                else chk("vec_data", vec_data, vq.pop_front());
            end
        end
    end
    task automatic do_init(input logic [7:0] i1, i2, i3, i4, o1, input int nexp);
        int w0, gaps;
        bit ok;
        w0 = n_wr;
        wq.push_back({1'b0, i1});
        wq.push_back({1'b1, i2});
        if (!i1[1]) wq.push_back({1'b1, i3});
        if (i1[0]) wq.push_back({1'b1, i4});
        wq.push_back({1'b1, o1});
        @(posedge clk); #1;
        {cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, cfg_ocw1} = {i1, i2, i3, i4, o1};
        cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
        chk("init_busy_set", cfg_busy, 1);
        chk("init_done_clr", cfg_done, 0);
        gaps = 0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cfg_done) begin ok = 1; break; end
            if (!cfg_busy) gaps++;
        end
        if (!ok) fail("init_timeout");
        chk("init_busy_gaps", gaps, 0);
        chk("init_busy_end", cfg_busy, 0);
        chk("init_write_count", n_wr - w0, nexp);
        chk("init_queue_left", wq.size(), 0);
    endtask
    task automatic do_cmd(input logic wr, input logic a0, input logic [7:0] d);
        bit ok;
        if (wr) wq.push_back({a0, d}); else rq.push_back(rdval);
        cmd_write = wr;
        cmd_a0 = a0;
        cmd_wdata = d;
        cmd_valid = 1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc_vseen = vseen;
                @(posedge clk); #1;
                cmd_valid = 0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin fail("cmd_accept_timeout"); cmd_valid = 0; end
        repeat (8) @(posedge clk);
        #1;
    endtask
    initial begin
        int v0;
        bit ok;
        #12;
        chk("reset_strobes", {pic_cs_n, pic_wr_n, pic_rd_n, pic_inta_n, pic_a0, db_oe}, 6'b111100);
        chk("reset_status", {cfg_busy, cfg_done, cmd_ready, rsp_valid, vec_valid}, 5'b00000);
        chk("reset_data", {db_out, rsp_rdata, vec_data}, 24'h0);
        @(posedge clk); #1;
        rst_n = 1;
        repeat (2) @(posedge clk); #1;
        rdval = 8'h0E;
        do_cmd(0, 0, 8'h00);
        do_init(8'h13, 8'h00, 8'hEE, 8'h03, 8'h00, 4);
        do_init(8'hF5, 8'h08, 8'h04, 8'h01, 8'hFB, 5);
        // abort an init in the middle of a write strobe
        @(posedge clk); #1;
        {cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4, cfg_ocw1} = {8'h13, 8'h20, 8'h00, 8'h01, 8'hFF};
        cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!pic_wr_n) begin ok = 1; break; end
        end
        if (!ok) fail("wr_pulse_timeout");
        #2 rst_n = 0;
        #1;
        chk("async_rst_pins", {pic_cs_n, pic_wr_n, db_oe}, 3'b110);
        chk("async_rst_status", {cfg_done, cfg_busy, cmd_ready}, 3'b000);
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        do_init(8'h12, 8'h40, 8'h00, 8'h00, 8'h7E, 3);
        // two back-to-back acknowledges with INT held high
        vecv = 8'h05;
        v0 = vseen;
        vq.push_back(8'h05);
        vq.push_back(8'h05);
        @(posedge clk); #1;
        int_en = 1;
        pic_int = 1;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (vseen >= v0 + 2) begin ok = 1; break; end
        end
        if (!ok) fail("vec_timeout");
        #1 pic_int = 0;
        repeat (12) @(posedge clk); #1;
        // INTA and a host read becoming eligible in the same IDLE cycle
        int_en = 0;
        pic_int = 1;
        repeat (6) @(posedge clk); #1;
        vecv = 8'h77;
        vq.push_back(8'h77);
        rdval = 8'h3C;
        v0 = vseen;
        int_en = 1;
        fork
            do_cmd(0, 0, 8'h00);
            begin
                ok = 0;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk);
                    if (vseen > v0) begin ok = 1; break; end
                end
                if (!ok) fail("arb_vec_timeout");
                #1 pic_int = 0;
            end
        join
        chk("arb_inta_first", acc_vseen, v0 + 1);
        int_en = 0;
        do_cmd(1, 1, 8'h5A);
        rdval = 8'hC3;
        do_cmd(0, 1, 8'h00);
        repeat (4) @(posedge clk); #1;
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        chk("vq_drained", vq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pic_host_sequencer.md
Name: pic_host_sequencer

Overview:
- Synchronous host-side controller for the 8259-style interrupt controller.
- Sequences the controller's asynchronous bus pins: CS/A0/WR/RD/INTA strobes and the split data bus.
- Runs the ICW1–ICW4 + OCW1 initialisation sequence from configuration inputs.
- Arbitrates between single host register reads/writes and automatic two-pulse INTA acknowledge cycles, returning the captured vector.

Parameters:
SETUP_CYC, 1, cycles CS_n/A0/data are stable before a WR_n/RD_n strobe falls (≥1)
PULSE_CYC, 2, strobe low width in cycles for WR_n, RD_n and each INTA_n pulse (≥1)
HOLD_CYC, 1, cycles CS_n/A0/data are held after a strobe rises (≥1)
GAP_CYC, 2, INTA_n high cycles between the first and second INTA pulse (≥1)
ACK_GAP, 4, cycles after an INTA sequence ends before pic_int is considered again

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  pulse; starts the init sequence
cfg_icw1  in  8  ICW1 value; bit1=SNGL, bit0=IC4
cfg_icw2  in  8  ICW2 value
cfg_icw3  in  8  ICW3 value; written only when SNGL=0
cfg_icw4  in  8  ICW4 value; written only when IC4=1
cfg_ocw1  in  8  interrupt mask written last
cfg_busy  out  1  init sequence in progress
cfg_done  out  1  init completed; level signal
cmd_valid  in  1  host register access request
cmd_ready  out  1  request accepted this cycle
cmd_write  in  1  1=write, 0=read
cmd_a0  in  1  A0 for the access
cmd_wdata  in  8  write data
rsp_valid  out  1  one-cycle pulse: read data valid
rsp_rdata  out  8  captured read data
int_en  in  1  enables automatic acknowledge
pic_int  in  1  controller INT output (asynchronous)
vec_valid  out  1  one-cycle pulse: vector valid
vec_data  out  8  captured interrupt vector
pic_cs_n  out  1  chip select
pic_a0  out  1  address bit
pic_wr_n  out  1  write strobe
pic_rd_n  out  1  read strobe
pic_inta_n  out  1  interrupt acknowledge strobe
db_out  out  8  data to the bus
db_oe  out  1  bus drive enable (tri-state is resolved at top level)
db_in  in  8  data from the bus

Behaviour:
Reset (asynchronous, immediate, including mid-cycle):
- All strobes (cs_n, wr_n, rd_n, inta_n) =1; pic_a0=0; db_oe=0; db_out=0.
- cfg_busy=0, cfg_done=0, cmd_ready=0, rsp_valid=0, vec_valid=0; rsp_rdata, vec_data =0.
- FSM returns to IDLE; the ACK_GAP counter is cleared.

Input sync: pic_int passes through a 2-flop synchroniser to give int_s.

FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_HOLD, A_P1, A_GAP, A_P2, A_END. A common down-counter times every state.

Write cycle:
- Entered the cycle after acceptance.
- cs_n=0, a0 valid, db_oe=1, db_out valid for SETUP+PULSE+HOLD cycles.
- wr_n=0 for the PULSE_CYC cycles only.
- Back in IDLE with all strobes high the following cycle.

Read cycle:
- Same framing as a write, with rd_n instead of wr_n; db_oe=0 throughout.
- db_in is sampled on the last PULSE cycle.
- rsp_valid pulses in the first cycle after R_HOLD.

INTA sequence:
- cs_n stays 1; db_oe=0.
- inta_n low PULSE_CYC cycles, high GAP_CYC cycles, low PULSE_CYC cycles.
- db_in is sampled on the last cycle of the second pulse.
- vec_valid pulses in A_END; ACK_GAP then reloads.

Init sequence:
- Latches all cfg_* values on cfg_start; sets cfg_busy=1 and clears cfg_done.
- Issues back-to-back write cycles: ICW1 (a0=0), ICW2 (a0=1), ICW3 (a0=1, only if SNGL=0), ICW4 (a0=1, only if IC4=1), OCW1 (a0=1).
- Each write is followed by one IDLE-equivalent cycle with all strobes high.
- After the last write: cfg_busy=0, cfg_done=1.

Arbitration (evaluated in IDLE only; each transaction is atomic):
1. cfg_start.
2. INTA, when cfg_done & int_en & int_s & gap counter = 0.
3. Host command.

Host command handshake:
- cmd_ready=1 only in IDLE when cfg_busy=0 and neither higher-priority source fires that cycle.
- Commands are accepted whether or not cfg_done=1.

Ignored / rejected inputs:
- cfg_start while not in IDLE or while cfg_busy=1 is ignored.
- cmd_valid held while cmd_ready=0 is not lost; the host keeps it asserted.

Output hold:
- rsp_rdata and vec_data hold their last captured value until the next capture.

Test Plan:
- Init: cfg_icw1=0x13, icw2=0x00, icw4=0x03, ocw1=0x00 → exactly 4 write cycles (0x13 a0=0; 0x00, 0x03, 0x00 a0=1); ICW3 not written; each write has cs_n low 4 cycles and wr_n low 2 cycles (defaults); cfg_done=1 afterwards.
- Cascade init: icw1=0xF5 (SNGL=0, IC4=1), icw3=0x04 → 5 writes with 0x04 as the third; cfg_busy high throughout.
- Acknowledge: int_en=1, pic_int=1, db_in=0x05 during the second pulse → two 2-cycle inta_n pulses separated by 2 high cycles, vec_valid once with vec_data=0x05; pic_int held high → next INTA is not started before ACK_GAP=4 cycles.
- Register read: cmd_write=0, cmd_a0=0, db_in=0x0E → rd_n low 2 cycles, db_oe=0, rsp_valid pulse with rsp_rdata=0x0E.
- Simultaneous cmd_valid and int_s in IDLE → INTA sequence first, cmd_ready=0 meanwhile; the command completes next.
- rst_n asserted during W_PULSE → wr_n, cs_n =1 and db_oe=0 without waiting for a clock edge; cfg_done=0; after release a fresh cfg_start runs the full sequence.
